// File: rtl/arm_core_pkg.sv
// Shared ARM core definitions: Thumb-2 32-bit instruction prefixes and the
// default halfword address width used by the fetch path.
package arm_core_pkg;

   localparam int unsigned AW_DEFAULT = 20;

   localparam logic [4:0] THUMB32_PFX_A = 5'b11101;
   localparam logic [4:0] THUMB32_PFX_B = 5'b11110;
   localparam logic [4:0] THUMB32_PFX_C = 5'b11111;

   // First halfword of a 32-bit Thumb-2 instruction is identified by its top five bits.
   function automatic logic is_thumb32(input logic [15:0] hw);
      return (hw[15:11] == THUMB32_PFX_A) ||
             (hw[15:11] == THUMB32_PFX_B) ||
             (hw[15:11] == THUMB32_PFX_C);
   endfunction

endpackage

// File: rtl/hw_fifo.sv
// Halfword queue for the instruction prefetcher: DEPTH entries of W bits,
// pointers carry an extra wrap bit so full and empty are distinguishable.
module hw_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 36
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  logic                    flush_i,
   input  logic [W-1:0]            wdata_i,
   output logic [W-1:0]            rdata_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [PW:0]  wr_ptr_q, wr_ptr_d;
   logic [PW:0]  rd_ptr_q, rd_ptr_d;
   logic         do_push;
   logic         do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign rdata_o = mem_q[rd_ptr_q[PW-1:0]];

   // A pop while full frees the very slot the simultaneous push lands in.
   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/inst_prefetch.sv
// Thumb instruction prefetcher: streams halfwords from a 1-cycle-latency memory
// into a small queue. Define INST_PREFETCH_STALL_CNT_EN to add the stall_cnt output.
module inst_prefetch
   import arm_core_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = AW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic [15:0]   mem_rdata,
   input  logic          branch_valid,
   input  logic [AW-1:0] branch_addr,
   output logic          hw_valid,
   input  logic          hw_ready,
   output logic [15:0]   hw_data,
   output logic [AW-1:0] hw_addr,
   output logic          hw_first32
`ifdef INST_PREFETCH_STALL_CNT_EN
   ,
   output logic [31:0]   stall_cnt
`endif
);

   localparam int unsigned   PW      = $clog2(DEPTH);
   localparam int unsigned   EW      = 16 + AW;
   localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

   logic [AW-1:0] fa_q, fa_d;
   logic          out_q, out_d;
   logic [AW-1:0] rsp_addr_q, rsp_addr_d;

   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [PW:0]   fifo_count;
   logic [EW-1:0] fifo_wdata;
   logic [EW-1:0] fifo_rdata;
   logic [PW+1:0] in_use;

   // Slots already promised: queued entries plus the response still on the bus.
   assign in_use   = {1'b0, fifo_count} + {{(PW+1){1'b0}}, out_q};
   assign mem_req  = !rst && !branch_valid && !fifo_full && (in_use < DEPTH_W);
   assign mem_addr = fa_q;

   assign fifo_push  = out_q && !branch_valid;
   assign fifo_pop   = hw_valid && hw_ready && !branch_valid;
   assign fifo_wdata = {rsp_addr_q, mem_rdata};

   assign hw_valid   = !fifo_empty;
   assign hw_data    = fifo_empty ? 16'h0000 : fifo_rdata[15:0];
   assign hw_addr    = fifo_empty ? '0 : fifo_rdata[EW-1:16];
   assign hw_first32 = is_thumb32(hw_data);

   always_comb begin
      fa_d       = fa_q;
      out_d      = 1'b0;
      rsp_addr_d = rsp_addr_q;
      if (branch_valid) begin
         fa_d = branch_addr;
      end else if (mem_req) begin
         fa_d       = fa_q + AW'(1);
         out_d      = 1'b1;
         rsp_addr_d = fa_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fa_q       <= '0;
         out_q      <= 1'b0;
         rsp_addr_q <= '0;
      end else begin
         fa_q       <= fa_d;
         out_q      <= out_d;
         rsp_addr_q <= rsp_addr_d;
      end
   end

   hw_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_hw_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .flush_i (branch_valid),
      .wdata_i (fifo_wdata),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

`ifdef INST_PREFETCH_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   // Core starved: it would take a halfword but none is available. Survives branches.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (hw_ready && !hw_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_prefetch.sv
// Scoreboard bench for inst_prefetch: directed phases push expected halfwords,
// a negedge monitor pops and compares every accepted hw transfer.
module tb_inst_prefetch;

   logic        clk;
   logic        rst;
   logic        mem_req;
   logic [19:0] mem_addr;
   logic [15:0] mem_rdata = 16'h0000;
   logic        branch_valid;
   logic [19:0] branch_addr;
   logic        hw_valid;
   logic        hw_ready;
   logic [15:0] hw_data;
   logic [19:0] hw_addr;
   logic        hw_first32;
`ifdef INST_PREFETCH_STALL_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] stall_snap;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   logic [35:0] exp_q [$];

   inst_prefetch #(.DEPTH(4), .AW(20)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_rdata    (mem_rdata),
      .branch_valid (branch_valid),
      .branch_addr  (branch_addr),
      .hw_valid     (hw_valid),
      .hw_ready     (hw_ready),
      .hw_data      (hw_data),
      .hw_addr      (hw_addr),
      .hw_first32   (hw_first32)
`ifdef INST_PREFETCH_STALL_CNT_EN
      ,
      .stall_cnt    (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory image: data equals the low address bits, with a few Thumb encodings at 0x100.
   function automatic logic [15:0] mem_fn(input logic [19:0] a);
      case (a)
         20'h00100: return 16'hF000;
         20'h00101: return 16'hE7FE;
         20'h00102: return 16'hE800;
         20'h00103: return 16'hBF08;
         default:   return a[15:0];
      endcase
   endfunction

   // One-cycle read latency: request seen at an edge, data driven just after it.
   logic        req_s;
   logic [19:0] addr_s;
   always @(posedge clk) begin
      req_s  = mem_req;
      addr_s = mem_addr;
      #1;
      mem_rdata = req_s ? mem_fn(addr_s) : 16'hDEAD;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic expect_hw(input logic [19:0] a);
      exp_q.push_back({a, mem_fn(a)});
   endtask

   // Monitor: every accepted transfer must match the head of the expected queue.
   always @(negedge clk) begin
      logic [35:0] e;
      logic [15:0] d;
      if (!rst && !branch_valid && hw_valid && hw_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_unexpected: got addr %0h data %0h expected nothing", hw_addr, hw_data);
         end else begin
            e = exp_q.pop_front();
            d = e[15:0];
            check("sb_addr", 32'(hw_addr), 32'(e[35:16]));
            check("sb_data", 32'(hw_data), 32'(d));
            check("sb_first32", 32'(hw_first32), 32'(d[15:11] >= 5'b11101));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; hw_ready = 1'b1; branch_valid = 1'b0; branch_addr = '0;
      step(); step(); #1;
      check("rst_mem_req", 32'(mem_req), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_hw_valid", 32'(hw_valid), 0);
      check("rst_hw_data", 32'(hw_data), 0);
      check("rst_hw_addr", 32'(hw_addr), 0);
      check("rst_hw_first32", 32'(hw_first32), 0);

      // Streaming from reset with hw_ready held high.
      for (int a = 0; a < 6; a++) expect_hw(20'(a));
      step(); rst = 1'b0; #1;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) begin step(); #1; end
         check("p1_mem_addr", 32'(mem_addr), 32'(c));
         check("p1_mem_req", 32'(mem_req), 1);
         check("p1_hw_valid", 32'(hw_valid), 32'(c >= 2));
      end

      // Reset mid-stream drops the in-flight response.
      step(); rst = 1'b1; #1;
      check("rst_mid_req", 32'(mem_req), 0);
      step(); #1;
      check("rst_mid_empty", 32'(hw_valid), 0);

      // Backpressure from reset: exactly four entries buffered.
      for (int a = 0; a < 6; a++) expect_hw(20'(a));
      step(); rst = 1'b0; hw_ready = 1'b0; #1;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) begin step(); #1; end
         check("bp_mem_addr", 32'(mem_addr), 32'((c < 4) ? c : 4));
         check("bp_mem_req", 32'(mem_req), 32'(c < 4));
         check("bp_hw_valid", 32'(hw_valid), 32'(c >= 2));
         if (c >= 2) begin
            check("bp_hw_data_hold", 32'(hw_data), 0);
            check("bp_hw_addr_hold", 32'(hw_addr), 0);
         end
      end
      step(); hw_ready = 1'b1; #1;
      check("bp_full_no_req", 32'(mem_req), 0);
      for (int c = 11; c < 16; c++) begin
         step(); #1;
         check("bp_drain_addr", 32'(mem_addr), 32'(c - 7));
         check("bp_drain_valid", 32'(hw_valid), 1);
      end

      // Branch with a response in flight; stale entries must never appear.
      step(); branch_valid = 1'b1; branch_addr = 20'h00100; #1;
      check("br_req_suppressed", 32'(mem_req), 0);
`ifdef INST_PREFETCH_STALL_CNT_EN
      stall_snap = stall_cnt;
`endif
      for (int a = 'h100; a < 'h105; a++) expect_hw(20'(a));
      step(); branch_valid = 1'b0; #1;
      check("br_first_req", 32'(mem_req), 1);
      check("br_first_addr", 32'(mem_addr), 32'h00100);
      check("br_gap0_valid", 32'(hw_valid), 0);
      step(); #1;
      check("br_gap1_valid", 32'(hw_valid), 0);
      check("br_second_addr", 32'(mem_addr), 32'h00101);
      step(); #1;
      check("br_hw_valid", 32'(hw_valid), 1);
      check("br_hw_addr", 32'(hw_addr), 32'h00100);
`ifdef INST_PREFETCH_STALL_CNT_EN
      check("stall_cnt_delta", stall_cnt - stall_snap, 2);
`endif
      for (int c = 20; c < 24; c++) begin
         step(); #1;
         check("br_stream_valid", 32'(hw_valid), 1);
      end

      // Address wrap at the top of the halfword space.
      step(); branch_valid = 1'b1; branch_addr = 20'hFFFFE; #1;
      expect_hw(20'hFFFFE); expect_hw(20'hFFFFF); expect_hw(20'h00000); expect_hw(20'h00001);
      step(); branch_valid = 1'b0; #1;
      check("wrap_addr0", 32'(mem_addr), 32'hFFFFE);
      step(); #1;
      check("wrap_addr1", 32'(mem_addr), 32'hFFFFF);
      step(); #1;
      check("wrap_addr2", 32'(mem_addr), 32'h00000);
      check("wrap_req", 32'(mem_req), 1);
      check("wrap_valid", 32'(hw_valid), 1);
      for (int c = 28; c < 31; c++) begin
         step(); #1;
         check("wrap_stream_valid", 32'(hw_valid), 1);
      end

      step(); rst = 1'b1;
      step(); step(); #1;
      check("sb_drained", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/inst_prefetch.md
INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning halfword queue entries (power of 2, min 2).
REQ-002 SHALL have parameter AW, default 20, meaning halfword address width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port mem_req  output  1  halfword read request to instruction memory.
REQ-006 SHALL have port mem_addr  output  AW  halfword address of the request.
REQ-007 SHALL have port mem_rdata  input  16  read data, valid exactly 1 cycle after mem_req.
REQ-008 SHALL have port branch_valid  input  1  redirect fetch stream.
REQ-009 SHALL have port branch_addr  input  AW  redirect target halfword address.
REQ-010 SHALL have port hw_valid  output  1  hw_data is valid.
REQ-011 SHALL have port hw_ready  input  1  core accepts hw_data.
REQ-012 SHALL have port hw_data  output  16  next Thumb halfword to the core.
REQ-013 SHALL have port hw_addr  output  AW  address of hw_data.
REQ-014 SHALL have port hw_first32  output  1  hw_data[15:11] is 11101, 11110 or 11111.

Function
REQ-015 SHALL hold fetch pointer fa; mem_addr SHALL equal fa; on each mem_req cycle fa SHALL increment by 1, wrapping modulo 2^AW.
REQ-016 SHALL assert mem_req only when occupancy + outstanding < DEPTH and branch_valid is 0; outstanding is 0 or 1.
REQ-017 SHALL write mem_rdata and its address into the queue the cycle after mem_req, unless discarded by REQ-020.
REQ-018 SHALL present the queue head on hw_data/hw_addr with hw_valid=1 when not empty; a pop SHALL occur on hw_valid & hw_ready.
REQ-019 SHALL support push and pop in the same cycle, occupancy unchanged, including when full or at 1 entry.
REQ-020 branch_valid SHALL take priority: same cycle, empty queue, drop any in-flight response, set fa=branch_addr, suppress mem_req, and ignore hw_ready.
REQ-021 SHALL issue the first post-branch request the cycle after branch_valid; min branch-to-hw_valid latency SHALL be 2 cycles.
REQ-022 Steady-state throughput with hw_ready held 1 SHALL be 1 halfword per cycle.
REQ-023 hw_data/hw_addr SHALL remain stable while hw_valid=1 and hw_ready=0.
REQ-024 Read/write queue pointers SHALL wrap modulo DEPTH, with an extra wrap bit to distinguish full from empty.

Reset
REQ-025 On rst: fa=0, queue empty, outstanding=0; mem_req=0, mem_addr=0, hw_valid=0, hw_data=0, hw_addr=0, hw_first32=0.
REQ-026 rst asserted mid-transfer SHALL discard the in-flight response; the first request after rst deasserts SHALL be to address 0.
REQ-027 rst SHALL take priority over branch_valid.

Configuration
REQ-028 Macro INST_PREFETCH_STALL_CNT_EN: when defined, SHALL add output stall_cnt (32) counting cycles with hw_ready=1 and hw_valid=0 (saturating, reset 0, not cleared by branch); when undefined the port and counter SHALL not exist.

Structure
REQ-029 Shared package arm_core_pkg SHALL hold the THUMB32 prefix constants (11101, 11110, 11111) and the default AW.
REQ-030 Queue storage and pointers SHALL be one sub-module, hw_fifo (parameterised DEPTH, width 16+AW, push/pop/flush/full/empty).

Verification
REQ-031 Reset release, hw_ready=1, memory[i]=i -> mem_addr 0,1,2,... one per cycle; hw_valid first at cycle 2 with hw_data=0000, then consecutive values 0001, 0002, ... with no gaps.
REQ-032 hw_ready=0 for 10 cycles -> exactly DEPTH=4 entries are buffered and mem_req drops; hw_data stays 0000. Raising hw_ready yields 0000..0003 then 0004 with no gap.
REQ-033 branch_valid with branch_addr=0x00100 while a response is in flight -> the stale halfword is not delivered; next hw_valid has hw_addr=0x00100 two cycles later.
REQ-034 fa=0xFFFFE with a continuous fetch -> mem_addr sequence is FFFFE, FFFFF, 00000.
REQ-035 hw_data=0xF000 -> hw_first32=1; 0xE7FE -> 0; 0xE800 -> 1; 0xBF08 -> 0.
REQ-036 With INST_PREFETCH_STALL_CNT_EN, branch plus hw_ready=1 -> stall_cnt increases by exactly 2 per branch.
